ysyx_22041211_lsu: RTL
======================

Name: ysyx_22041211_lsu

Overview:
- Load/store unit that consumes the execute stage's memory-access outputs: effective address (ALU result), store data, load/store type, and destination register.
- Issues a word-aligned request on a simple valid/ready data-memory bus and waits for the response.
- For loads, extracts and extends the addressed byte/half/word.
- Hands the result to write-back over a valid/ready handshake. Non-memory instructions pass through with the ALU result as write-back data.

Parameters:
- DATA_LEN, 32, datapath and address width; only 32 is supported.

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- exu_valid_i  input  1  execute stage presents a valid instruction
- lsu_ready_o  output  1  LSU can accept an instruction this cycle
- addr_i  input  32  effective address, or ALU result for non-memory ops
- wdata_i  input  32  store data (rs2 value)
- load_type_i  input  3  load type: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU
- store_type_i  input  2  store type: 00 none, 01 SB, 10 SH, 11 SW
- wd_i  input  1  register write enable
- wreg_i  input  5  destination register
- pc_i  input  32  instruction PC
- mem_req_valid_o  output  1  bus request valid
- mem_req_ready_i  input  1  bus accepts the request
- mem_req_addr_o  output  32  word address (addr with bits [1:0] = 0)
- mem_req_wen_o  output  1  1 = write, 0 = read
- mem_req_wdata_o  output  32  lane-shifted write data
- mem_req_wmask_o  output  4  byte-lane write strobes
- mem_rsp_valid_i  input  1  bus response valid
- mem_rsp_ready_o  output  1  LSU accepts the response
- mem_rsp_rdata_i  input  32  read data (full word)
- mem_rsp_err_i  input  1  bus error on this response
- wb_valid_o  output  1  write-back payload valid
- wb_ready_i  input  1  write-back accepts the payload
- wb_data_o  output  32  load result or pass-through ALU result
- wd_o  output  1  register write enable toward write-back
- wreg_o  output  5  destination register toward write-back
- pc_o  output  32  instruction PC toward write-back
- access_fault_o  output  1  misaligned access or bus error

Behaviour:
- States: IDLE, REQ, RSP, WB. Reset (rst = 0, asynchronous) forces IDLE.
- Reset values: every registered output and captured field is 0; mem_req_valid_o drops immediately when reset asserts, even mid-transfer; no partial write-back is produced.
- IDLE: lsu_ready_o = 1. A handshake occurs when exu_valid_i & lsu_ready_o; on it, capture all inputs. lsu_ready_o = 0 in every other state.
- IDLE, next state on handshake:
  - Memory op (load_type != 0 or store_type != 0), aligned: go to REQ.
  - Non-memory op: go to WB with wb_data = addr_i.
  - Misaligned (LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0): go to WB with access_fault = 1, wd = 0, wb_data = 0. No bus request is issued.
- REQ: mem_req_valid_o = 1, with addr/wen/wdata/wmask held stable until mem_req_ready_i = 1, then go to RSP. Responses arriving in REQ are ignored.
- RSP: mem_rsp_ready_o = 1 (0 in all other states). On mem_rsp_valid_i, go to WB.
  - If mem_rsp_err_i = 1: access_fault = 1, wd = 0, wb_data = 0.
  - Otherwise, loads store the extracted data; stores store wb_data = 0 and keep the captured wd (0 from decode).
- WB: wb_valid_o = 1, with payload held stable until wb_ready_i = 1, then go to IDLE. There is no IDLE bypass: the next instruction is accepted the cycle after the WB handshake.
- Store lanes, with o = addr[1:0]:
  - SB: wmask = 0001 << o; wdata = {4{wdata[7:0]}}.
  - SH: wmask = 0011 << o; wdata = {2{wdata[15:0]}}.
  - SW: wmask = 1111; wdata = wdata.
  - Loads: wmask = 0000, wen = 0.
- Load extraction: byte = rdata[8*o +: 8]; half = rdata[8*o +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns rdata.
- If both load_type and store_type are nonzero, treat the instruction as a store.
- Minimum latency with bus ready and single-cycle response: accept at cycle 0, REQ at 1, RSP at 2, wb_valid_o at 3. Non-memory op: wb_valid_o at cycle 1.
- Occupancy is one instruction at a time; no pipelining inside the block.

Test Plan:
- Reset asserted during REQ with mem_req_valid_o = 1 -> mem_req_valid_o = 0 in the same cycle; state is IDLE and lsu_ready_o = 1 after release; no wb_valid_o.
- LB at addr 0x80000003, rdata 0x8A000000 -> req addr 0x80000000, wen 0; wb_data_o = 0xFFFFFF8A, wd_o = 1; wb_valid_o rises 3 cycles after accept. The same access as LBU -> 0x0000008A.
- SH at addr 0x80000102, wdata 0x1234ABCD, mem_req_ready_i held low 3 cycles -> addr 0x80000100, wmask 1100, wdata 0xABCDABCD, all stable throughout the stall; wb_data_o = 0, wd_o = 0.
- LW at addr 0x80000006 -> no mem_req_valid_o; wb_valid_o next cycle with access_fault_o = 1, wd_o = 0.
- Non-memory op, addr_i = 0x00000042, wd_i = 1, wreg_i = 5, wb_ready_i low 2 cycles -> wb_valid_o held 3 cycles with wb_data_o = 0x42, wreg_o = 5; lsu_ready_o = 0 until the cycle after the handshake.
- SW whose response returns mem_rsp_err_i = 1 -> access_fault_o = 1, wd_o = 0; a back-to-back LW issued afterwards completes normally with access_fault_o = 0.

Source files
------------

// File: rtl/ysyx_22041211_lsu.sv
// Load/store unit: captures one execute-stage instruction, performs at most one
// word-aligned bus transaction, then presents the write-back payload.
module ysyx_22041211_lsu #(
   parameter int unsigned DATA_LEN = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                exu_valid_i,
   output logic                lsu_ready_o,
   input  logic [DATA_LEN-1:0] addr_i,
   input  logic [DATA_LEN-1:0] wdata_i,
   input  logic [2:0]          load_type_i,
   input  logic [1:0]          store_type_i,
   input  logic                wd_i,
   input  logic [4:0]          wreg_i,
   input  logic [DATA_LEN-1:0] pc_i,
   output logic                mem_req_valid_o,
   input  logic                mem_req_ready_i,
   output logic [DATA_LEN-1:0] mem_req_addr_o,
   output logic                mem_req_wen_o,
   output logic [DATA_LEN-1:0] mem_req_wdata_o,
   output logic [3:0]          mem_req_wmask_o,
   input  logic                mem_rsp_valid_i,
   output logic                mem_rsp_ready_o,
   input  logic [DATA_LEN-1:0] mem_rsp_rdata_i,
   input  logic                mem_rsp_err_i,
   output logic                wb_valid_o,
   input  logic                wb_ready_i,
   output logic [DATA_LEN-1:0] wb_data_o,
   output logic                wd_o,
   output logic [4:0]          wreg_o,
   output logic [DATA_LEN-1:0] pc_o,
   output logic                access_fault_o
);

   typedef enum logic [1:0] {StIdle, StReq, StRsp, StWb} state_e;

   state_e              state_q, state_d;
   logic [DATA_LEN-1:0] addr_q, addr_d;
   logic [DATA_LEN-1:0] wdata_q, wdata_d;
   logic [3:0]          wmask_q, wmask_d;
   logic                wen_q, wen_d;
   logic [2:0]          ltype_q, ltype_d;
   logic                wd_q, wd_d;
   logic [4:0]          wreg_q, wreg_d;
   logic [DATA_LEN-1:0] pc_q, pc_d;
   logic [DATA_LEN-1:0] wb_data_q, wb_data_d;
   logic                fault_q, fault_d;

   logic                is_store, is_load, misaligned;
   logic [1:0]          off_i;
   logic [DATA_LEN-1:0] st_wdata;
   logic [3:0]          st_wmask;
   logic [DATA_LEN-1:0] rsp_shifted;
   logic [DATA_LEN-1:0] load_data;

   // Decode the incoming instruction: store wins when both types are set.
   always_comb begin
      is_store   = (store_type_i != 2'b00);
      is_load    = !is_store && (load_type_i != 3'b000);
      off_i      = addr_i[1:0];
      misaligned = 1'b0;
      st_wdata   = '0;
      st_wmask   = 4'b0000;
      if (is_store) begin
         unique case (store_type_i)
            2'b01: begin
               st_wmask = 4'b0001 << off_i;
               st_wdata = {4{wdata_i[7:0]}};
            end
            2'b10: begin
               st_wmask   = 4'b0011 << off_i;
               st_wdata   = {2{wdata_i[15:0]}};
               misaligned = addr_i[0];
            end
            default: begin
               st_wmask   = 4'b1111;
               st_wdata   = wdata_i;
               misaligned = (off_i != 2'b00);
            end
         endcase
      end else if (is_load) begin
         if (load_type_i == 3'b010 || load_type_i == 3'b101) misaligned = addr_i[0];
         if (load_type_i == 3'b011) misaligned = (off_i != 2'b00);
      end
   end

   // Extract and extend the addressed lane of the response word.
   always_comb begin
      rsp_shifted = mem_rsp_rdata_i >> {addr_q[1:0], 3'b000};
      unique case (ltype_q)
         3'b001:  load_data = {{(DATA_LEN-8){rsp_shifted[7]}}, rsp_shifted[7:0]};
         3'b010:  load_data = {{(DATA_LEN-16){rsp_shifted[15]}}, rsp_shifted[15:0]};
         3'b100:  load_data = {{(DATA_LEN-8){1'b0}}, rsp_shifted[7:0]};
         3'b101:  load_data = {{(DATA_LEN-16){1'b0}}, rsp_shifted[15:0]};
         default: load_data = mem_rsp_rdata_i;
      endcase
   end

   // Next-state logic and capture of the instruction fields.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wmask_d   = wmask_q;
      wen_d     = wen_q;
      ltype_d   = ltype_q;
      wd_d      = wd_q;
      wreg_d    = wreg_q;
      pc_d      = pc_q;
      wb_data_d = wb_data_q;
      fault_d   = fault_q;
      unique case (state_q)
         StIdle: begin
            if (exu_valid_i) begin
               addr_d    = addr_i;
               wdata_d   = st_wdata;
               wmask_d   = st_wmask;
               wen_d     = is_store;
               ltype_d   = is_store ? 3'b000 : load_type_i;
               wd_d      = wd_i;
               wreg_d    = wreg_i;
               pc_d      = pc_i;
               wb_data_d = '0;
               fault_d   = 1'b0;
               if (!(is_store || is_load)) begin
                  wb_data_d = addr_i;
                  state_d   = StWb;
               end else if (misaligned) begin
                  fault_d = 1'b1;
                  wd_d    = 1'b0;
                  state_d = StWb;
               end else begin
                  state_d = StReq;
               end
            end
         end
         StReq: begin
            if (mem_req_ready_i) state_d = StRsp;
         end
         StRsp: begin
            if (mem_rsp_valid_i) begin
               state_d = StWb;
               if (mem_rsp_err_i) begin
                  fault_d   = 1'b1;
                  wd_d      = 1'b0;
                  wb_data_d = '0;
               end else begin
                  wb_data_d = wen_q ? '0 : load_data;
               end
            end
         end
         default: begin
            if (wb_ready_i) state_d = StIdle;
         end
      endcase
   end

   // State and captured-field registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         wdata_q   <= '0;
         wmask_q   <= '0;
         wen_q     <= 1'b0;
         ltype_q   <= '0;
         wd_q      <= 1'b0;
         wreg_q    <= '0;
         pc_q      <= '0;
         wb_data_q <= '0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wmask_q   <= wmask_d;
         wen_q     <= wen_d;
         ltype_q   <= ltype_d;
         wd_q      <= wd_d;
         wreg_q    <= wreg_d;
         pc_q      <= pc_d;
         wb_data_q <= wb_data_d;
         fault_q   <= fault_d;
      end
   end

   // Handshake strobes decode straight from state so reset kills them at once.
   always_comb begin
      lsu_ready_o     = (state_q == StIdle);
      mem_req_valid_o = (state_q == StReq);
      mem_rsp_ready_o = (state_q == StRsp);
      wb_valid_o      = (state_q == StWb);
      mem_req_addr_o  = {addr_q[DATA_LEN-1:2], 2'b00};
      mem_req_wen_o   = wen_q;
      mem_req_wdata_o = wdata_q;
      mem_req_wmask_o = wmask_q;
      wb_data_o       = wb_data_q;
      wd_o            = wd_q;
      wreg_o          = wreg_q;
      pc_o            = pc_q;
      access_fault_o  = fault_q;
   end

endmodule
